uart_word_rx: RTL and testbench

- Serial receive front end that assembles two 8N1 UART bytes into a 16-bit word.
- Presents the word with a one-cycle load strobe to the 16-bit load-enabled holding register directly downstream; word_out drives its d, load drives its load.
- Sits between the board RX pin and the data register. Runs entirely in the system clock domain.

---
 rtl/uart_word_rx_pkg.sv | 18 +
 rtl/uart_word_rx_baud_tick.sv | 29 ++
 rtl/uart_word_rx.sv | 107 ++++++++++
 tb/tb_uart_word_rx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_word_rx_pkg.sv
// Shared definitions for the UART word receiver: FSM encoding, byte-pairing
// selectors and the default bit period.
package uart_word_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  localparam logic BYTE_LOW  = 1'b0;
  localparam logic BYTE_HIGH = 1'b1;

  // 100 MHz system clock / 115200 baud
  localparam int DEFAULT_BAUD_DIV = 868;

endpackage

// File: rtl/uart_word_rx_baud_tick.sv
// Bit-period counter: counts 0..limit-1, pulses tick on the last count and
// reloads. clear holds it at zero.
module uart_baud_tick #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic [W-1:0] limit,
  output logic         tick
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt;

  assign tick = !clear && (cnt == (limit - ONE));

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/uart_word_rx.sv
// 8N1 serial receiver that pairs two bytes (low first) into a 16-bit word and
// presents it with a one-cycle load strobe to a downstream holding register.
module uart_word_rx
  import uart_word_rx_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rxd,
  output logic [15:0] word_out,
  output logic        load,
  output logic        frame_err,
  output logic        busy
);

  localparam logic [15:0] BAUD_LIM = 16'(BAUD_DIV);
  localparam logic [15:0] HALF_LIM = 16'(HALF_DIV);

  rx_state_t   state, state_next;
  logic        rxd_m, rxd_s;
  logic        tick;
  logic        cnt_clear;
  logic [15:0] cnt_limit;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic [7:0]  low_byte;
  logic        byte_sel;
  logic        armed;
  logic        shift_en, stop_ok, stop_bad;

  uart_baud_tick #(.W(16)) u_baud (
    .clock (clock),
    .reset (reset),
    .clear (cnt_clear),
    .limit (cnt_limit),
    .tick  (tick)
  );

  always_ff @(posedge clock) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // armed drops after a bad stop bit so a held-low line (break) cannot
  // immediately look like a new start bit.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (armed && !rxd_s) state_next = ST_START;
      ST_START: if (tick) state_next = rxd_s ? ST_IDLE : ST_DATA;
      ST_DATA:  if (tick && (bit_cnt == 3'd7)) state_next = ST_STOP;
      ST_STOP:  if (tick) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != ST_IDLE);
    cnt_clear = (state == ST_IDLE);
    cnt_limit = (state == ST_START) ? HALF_LIM : BAUD_LIM;
    shift_en  = (state == ST_DATA) && tick;
    stop_ok   = (state == ST_STOP) && tick && rxd_s;
    stop_bad  = (state == ST_STOP) && tick && !rxd_s;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rxd_m     <= 1'b1;
      rxd_s     <= 1'b1;
      bit_cnt   <= '0;
      shift     <= '0;
      low_byte  <= '0;
      byte_sel  <= BYTE_LOW;
      armed     <= 1'b1;
      word_out  <= '0;
      load      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rxd_m     <= rxd;
      rxd_s     <= rxd_m;
      load      <= 1'b0;
      frame_err <= 1'b0;
      if ((state == ST_IDLE) && rxd_s) armed <= 1'b1;
      if (state != ST_DATA) bit_cnt <= '0;
      else if (shift_en)    bit_cnt <= bit_cnt + 3'd1;
      if (shift_en) shift <= {rxd_s, shift[7:1]};
      if (stop_ok) begin
        if (byte_sel == BYTE_LOW) begin
          low_byte <= shift;
          byte_sel <= BYTE_HIGH;
        end else begin
          word_out <= {shift, low_byte};
          load     <= 1'b1;
          byte_sel <= BYTE_LOW;
        end
      end
      if (stop_bad) begin
        frame_err <= 1'b1;
        byte_sel  <= BYTE_LOW;
        armed     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_word_rx.sv
// Bench for uart_word_rx: directed frame table, hand-written corner cases and
// random frames scored against a byte-pairing model with cycle-exact events.
module tb_uart_word_rx;

  localparam int B   = 16;
  localparam int H   = B / 2;
  localparam int LAT = 3 + H + 9 * B;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rxd   = 1'b1;
  logic [15:0] word_out;
  logic        load, frame_err, busy;

  uart_word_rx #(.BAUD_DIV(B)) dut (
    .clock     (clock),
    .reset     (reset),
    .rxd       (rxd),
    .word_out  (word_out),
    .load      (load),
    .frame_err (frame_err),
    .busy      (busy)
  );

  // clock / reset bookkeeping
  always #5 clock = ~clock;

  int   cyc = 0;
  logic rst_seen = 1'b0;
  bit   mon_on = 1'b0;
  always @(posedge clock) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  int          checks = 0;
  int          errors = 0;
  logic [47:0] exp_q[$];   // {cycle, word}
  logic [31:0] err_q[$];   // cycle
  logic [15:0] last_word = 16'h0000;
  logic        exp_load, exp_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // scoreboard
  always @(negedge clock) begin
    if (mon_on) begin
      if (!rst_seen) begin
        chk("reset_word", word_out, 0);
        chk("reset_load", load, 0);
        chk("reset_ferr", frame_err, 0);
        chk("reset_busy", busy, 0);
        last_word = 16'h0000;
      end else begin
        chk("exclusive", load & frame_err, 0);
        exp_load = (exp_q.size() > 0) && (exp_q[0][47:16] == 32'(cyc));
        chk("load", load, exp_load);
        if (load && exp_load) begin
          chk("word", word_out, exp_q[0][15:0]);
          last_word = exp_q[0][15:0];
        end else if (!load) begin
          chk("hold", word_out, last_word);
        end
        if ((exp_q.size() > 0) && (exp_q[0][47:16] <= 32'(cyc))) void'(exp_q.pop_front());
        exp_err = (err_q.size() > 0) && (err_q[0] == 32'(cyc));
        chk("frame_err", frame_err, exp_err);
        if ((err_q.size() > 0) && (err_q[0] <= 32'(cyc))) void'(err_q.pop_front());
      end
    end
  end

  // driver tasks: all are entered and left 1 time unit after a posedge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int gap);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      if (i == 1) chk("busy_mid", busy, 1);
      tick(B);
    end
    rxd = 1'b1;
    tick(gap);
  endtask

  task automatic expect_word(input logic [15:0] w);
    exp_q.push_back({32'(cyc + LAT), w});
  endtask

  task automatic expect_err();
    err_q.push_back(32'(cyc + LAT));
  endtask

  task automatic glitch(input int len);
    rxd = 1'b0;
    tick(len);
    rxd = 1'b1;
    tick(H + 6);
    chk("glitch_idle", busy, 0);
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    int          gap;
    logic        exp_load;
    logic [15:0] exp_word;
    logic        exp_err;
  } vec_t;

  vec_t        vecs[9];
  logic        pending;
  logic [7:0]  low_model;
  logic [7:0]  d;
  logic        stop;

  initial begin
    vecs[0] = '{8'h34, 1'b1, 0,  1'b0, 16'h0000, 1'b0};
    vecs[1] = '{8'h12, 1'b1, 20, 1'b1, 16'h1234, 1'b0};
    vecs[2] = '{8'hA5, 1'b0, 20, 1'b0, 16'h0000, 1'b1};
    vecs[3] = '{8'hCD, 1'b1, 0,  1'b0, 16'h0000, 1'b0};
    vecs[4] = '{8'hAB, 1'b1, 20, 1'b1, 16'hABCD, 1'b0};
    vecs[5] = '{8'h01, 1'b1, 0,  1'b0, 16'h0000, 1'b0};
    vecs[6] = '{8'h00, 1'b1, 0,  1'b1, 16'h0001, 1'b0};
    vecs[7] = '{8'hFF, 1'b1, 0,  1'b0, 16'h0000, 1'b0};
    vecs[8] = '{8'hFF, 1'b1, 20, 1'b1, 16'hFFFF, 1'b0};

    // reset low for 3 edges with the line idle
    reset = 1'b0;
    rxd   = 1'b1;
    tick(1);
    mon_on = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(10);
    chk("idle_busy", busy, 0);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].exp_load) expect_word(vecs[i].exp_word);
      if (vecs[i].exp_err)  expect_err();
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].gap);
    end
    chk("word_after_table", word_out, 16'hFFFF);

    // short low pulse must be rejected as a false start
    rxd = 1'b0;
    tick(5);
    chk("glitch_busy", busy, 1);
    rxd = 1'b1;
    tick(H + 6);
    chk("glitch_idle", busy, 0);

    // reset during the high byte discards the pending low byte
    send_frame(8'h11, 1'b1, 5);
    rxd = 1'b0;
    tick(B);
    rxd = 1'b0;
    tick(B);
    rxd = 1'b1;
    tick(B);
    chk("busy_before_reset", busy, 1);
    reset = 1'b0;
    rxd   = 1'b1;
    tick(3);
    reset = 1'b1;
    chk("busy_after_reset", busy, 0);
    tick(10);
    chk("word_after_reset", word_out, 16'h0000);
    send_frame(8'h22, 1'b1, 3);
    expect_word(16'h3322);
    send_frame(8'h33, 1'b1, 10);
    chk("word_3322", word_out, 16'h3322);

    // random frames against the pairing model
    pending   = 1'b0;
    low_model = 8'h00;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        glitch($urandom_range(1, H - 1));
      end else begin
        d    = 8'($urandom_range(0, 255));
        stop = ($urandom_range(0, 7) != 0);
        if (!stop) begin
          expect_err();
          pending = 1'b0;
        end else if (pending) begin
          expect_word({d, low_model});
          pending = 1'b0;
        end else begin
          low_model = d;
          pending   = 1'b1;
        end
        send_frame(d, stop, stop ? $urandom_range(0, 6) : $urandom_range(4, 10));
      end
    end

    tick(LAT);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("err_q_empty", err_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
